// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment scan driver.
// Holds segment constants, the scan state encoding and the digit index type.
package seg7_pkg;

    // Active-low segments, a..g MSB..LSB
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ON
    } scan_state_t;

    // 0: units, 1: tens
    typedef logic digit_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the end of the blanking guard
// and the end of the slot. Ports: clk, rst_n, clr, en -> blank_done, slot_done.
module seg7_slot_timer #(
    parameter int DIV          = 50_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic blank_done,
    output logic slot_done
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST       = W'(DIV - 1);
    localparam logic [W-1:0] BLANK_LAST = W'(BLANK_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // Wraps by itself so the next slot starts at 0
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign blank_done = (cnt == BLANK_LAST);
    assign slot_done  = (cnt == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a latched two-digit segment pattern onto one SEG bus with
// per-digit anodes. Ports: CLK, RST_N, D7[13:0], EN -> AN[1:0], SEG[6:0], FRAME.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV          = 50_000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [13:0] D7,
    input  logic        EN,
    output logic [1:0]  AN,
    output logic [6:0]  SEG,
    output logic        FRAME
);

    scan_state_t state, state_n;
    digit_t      digit, digit_n;
    logic [13:0] latch, latch_n;
    logic [1:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_n;
    logic        timer_clr;
    logic        timer_en;
    logic        blank_done;
    logic        slot_done;
    logic        tens_dark;

    seg7_slot_timer #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clr        (timer_clr),
        .en         (timer_en),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    // Leading-zero suppression keys off the latched frame, never live D7
    assign tens_dark = (LZ_BLANK != 0) && (latch[13:7] == SEG_ZERO);

    always_comb begin
        state_n   = state;
        digit_n   = digit;
        latch_n   = latch;
        an_n      = AN;
        seg_n     = SEG;
        frame_n   = 1'b0;
        timer_clr = 1'b0;
        timer_en  = (state != IDLE);

        if (!EN) begin
            state_n   = IDLE;
            digit_n   = 1'b0;
            an_n      = 2'b11;
            seg_n     = SEG_BLANK;
            timer_clr = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n   = GUARD;
                    digit_n   = 1'b0;
                    latch_n   = D7;
                    seg_n     = D7[6:0];
                    an_n      = 2'b11;
                    frame_n   = 1'b1;
                    timer_clr = 1'b1;
                end
                GUARD: begin
                    an_n = 2'b11;
                    if (blank_done) begin
                        state_n = ON;
                        if (digit)
                            an_n = tens_dark ? 2'b11 : 2'b01;
                        else
                            an_n = 2'b10;
                    end
                end
                ON: begin
                    if (slot_done) begin
                        state_n = GUARD;
                        an_n    = 2'b11;
                        if (digit) begin
                            // Tens -> units wrap: new frame, resample D7
                            digit_n = 1'b0;
                            latch_n = D7;
                            seg_n   = D7[6:0];
                            frame_n = 1'b1;
                        end else begin
                            digit_n = 1'b1;
                            seg_n   = tens_dark ? SEG_BLANK : latch[13:7];
                        end
                    end
                end
                default: begin
                    state_n   = IDLE;
                    an_n      = 2'b11;
                    seg_n     = SEG_BLANK;
                    timer_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            digit <= 1'b0;
            latch <= 14'h3FFF;
            AN    <= 2'b11;
            SEG   <= SEG_BLANK;
            FRAME <= 1'b0;
        end else begin
            state <= state_n;
            digit <= digit_n;
            latch <= latch_n;
            AN    <= an_n;
            SEG   <= seg_n;
            FRAME <= frame_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=8, BLANK_CYCLES=2, LZ_BLANK=1.
// Frame is 16 clocks: digit0 guard 2 / on 6, digit1 guard 2 / on 6.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [13:0] D7;
    logic        EN;
    logic [1:0]  AN;
    logic [6:0]  SEG;
    logic        FRAME;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [13:0] D_A  = 14'h0481;
    localparam logic [13:0] D_LZ = {7'b0000001, 7'b1001111};
    localparam logic [13:0] D_P  = {7'b0010010, 7'b0100100};
    localparam logic [13:0] D_Q  = {7'b0000110, 7'b1001100};
    localparam logic [9:0]  DARK = {2'b11, 7'h7F, 1'b0};

    seg7_scan_driver #(
        .DIV          (8),
        .BLANK_CYCLES (2),
        .LZ_BLANK     (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D7    (D7),
        .EN    (EN),
        .AN    (AN),
        .SEG   (SEG),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected {AN,SEG,FRAME} at cycle i (0 = frame start) for latched d
    function automatic logic [9:0] exp_out(int i, logic [13:0] d);
        logic [1:0] an;
        logic [6:0] seg;
        logic       dark;
        dark = (d[13:7] == 7'b0000001);
        if (i < 8)
            seg = d[6:0];
        else
            seg = dark ? 7'h7F : d[13:7];
        if ((i % 8) < 2)
            an = 2'b11;
        else if (i < 8)
            an = 2'b10;
        else
            an = dark ? 2'b11 : 2'b01;
        return {an, seg, (i == 0)};
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        EN    = 1'b1;
        D7    = D_A;
        tick();
        n_cmp++;
        if (AN !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_an got %b want 11", AN);
        end
        n_cmp++;
        if (SEG !== 7'h7F) begin
            n_bad++;
            $display("FAIL reset_seg got %h want 7f", SEG);
        end
        n_cmp++;
        if (FRAME !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_frame got %b want 0", FRAME);
        end
        EN    = 1'b0;
        RST_N = 1'b1;
        tick();
        n_cmp++;
        if ({AN, SEG, FRAME} !== DARK) begin
            n_bad++;
            $display("FAIL idle_dark got %h want %h", {AN, SEG, FRAME}, DARK);
        end
    endtask

    task automatic test_scan();
        D7 = D_A;
        EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_A)) begin
                n_bad++;
                $display("FAIL scan cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_A));
            end
        end
    endtask

    task automatic test_lz_blank();
        D7 = D_LZ;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_LZ)) begin
                n_bad++;
                $display("FAIL lz cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_LZ));
            end
        end
    endtask

    task automatic test_no_tear();
        D7 = D_P;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_P)) begin
                n_bad++;
                $display("FAIL tear_old cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_P));
            end
            if (i == 5)
                D7 = D_Q;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_Q)) begin
                n_bad++;
                $display("FAIL tear_new cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_Q));
            end
        end
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 11; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_Q)) begin
                n_bad++;
                $display("FAIL pre_drop cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_Q));
            end
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== DARK) begin
                n_bad++;
                $display("FAIL en_drop cyc %0d got %h want %h", i, {AN, SEG, FRAME}, DARK);
            end
        end
        EN = 1'b1;
        D7 = D_A;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_A)) begin
                n_bad++;
                $display("FAIL re_en cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_A));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_A)) begin
                n_bad++;
                $display("FAIL pre_rst cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_A));
            end
        end
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if ({AN, SEG, FRAME} !== DARK) begin
            n_bad++;
            $display("FAIL async_rst got %h want %h", {AN, SEG, FRAME}, DARK);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        D7    = D_P;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({AN, SEG, FRAME} !== exp_out(i, D_P)) begin
                n_bad++;
                $display("FAIL post_rst cyc %0d got %h want %h", i, {AN, SEG, FRAME}, exp_out(i, D_P));
            end
        end
    endtask

    task automatic test_random();
        logic prev_frame;
        prev_frame = FRAME;
        for (int i = 0; i < 10000; i++) begin
            EN = ($urandom_range(0, 63) != 0);
            D7 = 14'($urandom);
            tick();
            n_cmp++;
            if (AN === 2'b00) begin
                n_bad++;
                $display("FAIL rnd_an cyc %0d got %b want not 00", i, AN);
            end
            n_cmp++;
            if (prev_frame === 1'b1 && FRAME === 1'b1) begin
                n_bad++;
                $display("FAIL rnd_frame cyc %0d got 11 want width 1", i);
            end
            prev_frame = FRAME;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_blank();
        test_no_tear();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
